siso_loop_ctrl: RTL and testbench
=================================

# siso_loop_ctrl

Transfer controller for the serial-in/serial-out shift chain. Accepts a parallel word over a valid/ready handshake, drives it LSB-first onto the chain's `sin`, and recaptures the word from `sdo` once it has crossed the chain's fixed delay. Presents the recovered word with a loopback-match flag. Sits between a parallel producer/consumer and one SISO chain instance, and is the only driver of that chain's `sin`.

## Interface

**Parameters**

- `WIDTH`, default 8: word width in bits; must be ≥ 1.
- `DEPTH`, default 4: number of flip-flop stages in the attached SISO chain; must be ≥ 1.

**Ports**

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `in_valid`  in  1  a producer word is offered.
- `in_ready`  out  1  controller can accept a word.
- `in_data`  in  WIDTH  word to transmit.
- `sin`  out  1  registered serial output to the chain input.
- `sdo`  in  1  serial input from the chain output.
- `out_valid`  out  1  recovered word available.
- `out_ready`  in  1  consumer accepts the recovered word.
- `out_data`  out  WIDTH  recovered word.
- `out_match`  out  1  `out_data` equals the transmitted word; qualified by `out_valid`.
- `busy`  out  1  high in SHIFT or DONE.

## Operation

- **Reset values:** state IDLE, `in_ready`=1, `sin`=0, `out_valid`=0, `out_data`=0, `out_match`=0, `busy`=0, counter 0.
- **FSM states:** IDLE, SHIFT, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid && in_ready` at edge A:
    - latch `in_data` into `tx_q`;
    - clear the counter and `rx_q`;
    - go to SHIFT.
- **SHIFT**
  - `in_ready`=0; `in_valid` is ignored.
  - The counter runs for WIDTH+DEPTH cycles.
  - Bit k of `tx_q` (k = 0…WIDTH−1, LSB first) is registered onto `sin` at edge A+k+1.
  - After the last bit, `sin` returns to 0.
  - Capture: at edges A+DEPTH+1 … A+DEPTH+WIDTH, shift `sdo` in with `rx_q <= {sdo, rx_q[WIDTH-1:1]}`. The LSB arrives first and ends at bit 0.
  - After the capture at A+DEPTH+WIDTH, go to DONE.
- **DONE**
  - `out_valid`=1.
  - `out_data`=`rx_q` and `out_match`=(`rx_q`==`tx_q`); both held stable while `out_valid && !out_ready`.
  - On `out_valid && out_ready`, go to IDLE with `out_valid`=0.
- **Stale chain contents:** the chain is not flushed. The capture window contains only bits driven in the current transfer, so contents left by a previous or aborted transfer never reach `rx_q`.
- **Reset mid-operation:** asserting `rst_n` low in any state aborts the transfer immediately and forces all reset values. The word in flight is dropped and not reported.
- **Counter width:** `$clog2(WIDTH+DEPTH+1)` bits; the counter never wraps within a transfer.

## Timing

- Acceptance edge A to `out_valid` high: exactly WIDTH+DEPTH cycles (12 at the defaults). `out_valid` is first seen after edge A+WIDTH+DEPTH.
- `sin` carries bit k from edge A+k+1 until edge A+k+2.
- Minimum spacing between acceptances: WIDTH+DEPTH+2 cycles (one DONE cycle plus one IDLE cycle with `out_ready` held high).
- Throughput is one word in flight at a time; `in_ready` and `busy` are exact complements.
- All outputs are registered or decoded directly from state; there is no combinational path from `in_valid` or `out_ready` to any output.

## Structure

- **Package `siso_pkg`:**
  - `siso_state_e` enum (IDLE, SHIFT, DONE);
  - localparam `SISO_IDLE_LVL` = 1'b0, the `sin` idle level.
- **No sub-module:** the controller is a single module.
- **Bench:** instantiates the controller with a DEPTH-stage SISO chain connected `sin`→chain→`sdo`. A bench-side fault-injection mux on `sdo` is allowed.

## Test plan

- **Basic transfer** (WIDTH=8, DEPTH=4): `in_data`=8'hA5 accepted at A → `sin` = 1,0,1,0,0,1,0,1 after edges A+1…A+8; `out_valid` after A+12; `out_data`=8'hA5, `out_match`=1.
- **Fault injection:** invert `sdo` for the single capture edge of bit 2, `in_data`=8'h0F → `out_data`=8'h0B, `out_match`=0.
- **Backpressure:** `out_ready`=0 for 5 cycles in DONE → `out_valid`, `out_data` and `out_match` stable; `in_ready`=0; `in_valid` pulses ignored. `out_ready`=1 → IDLE next cycle.
- **Reset mid-shift:** assert `rst_n` low at A+5 → all outputs at reset values. Next transfer 8'h3C → `out_data`=8'h3C, `out_match`=1, no remnant of the aborted word.
- **Back-to-back:** 8'hFF then 8'h00 with `out_ready` tied 1 → second `out_data`=8'h00, `out_match`=1; acceptances exactly 14 cycles apart.
- **Edge parameters:** WIDTH=1, DEPTH=1, `in_data`=1 → `out_valid` 2 cycles after acceptance, `out_data`=1.

Source files
------------

// File: rtl/siso_pkg.sv
`default_nettype none
// ============================================================================
// siso_pkg : shared state type and idle level for the SISO loopback controller
// Revision  : 1.0
// ============================================================================
package siso_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } siso_state_e;

  localparam logic SISO_IDLE_LVL = 1'b0;

endpackage
`default_nettype wire

// File: rtl/siso_loop_ctrl.sv
`default_nettype none
// ============================================================================
// siso_loop_ctrl : sends a word LSB-first into a SISO chain, recaptures it
// Revision       : 1.0
// ============================================================================
module siso_loop_ctrl
  import siso_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             sin,
  input  logic             sdo,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_match,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + DEPTH + 1);
  localparam logic [CNT_W-1:0] W_CNT    = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] D_CNT    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH + DEPTH - 1);

  siso_state_e      state, state_next;
  logic [WIDTH-1:0] tx_q;
  logic [WIDTH-1:0] tx_sh;
  logic [WIDTH-1:0] rx_q;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == LAST_CNT) state_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // tx_sh is a working copy drained onto sin; tx_q keeps the word for the match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q  <= '0;
      tx_sh <= '0;
      rx_q  <= '0;
      cnt   <= '0;
      sin   <= SISO_IDLE_LVL;
    end else begin
      sin <= SISO_IDLE_LVL;
      case (state)
        IDLE: begin
          if (in_valid) begin
            tx_q  <= in_data;
            tx_sh <= in_data;
            rx_q  <= '0;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          cnt <= cnt + 1'b1;
          if (cnt < W_CNT) begin
            sin   <= tx_sh[0];
            tx_sh <= tx_sh >> 1;
          end
          // Window opens only once this transfer's bit 0 has crossed the chain.
          if (cnt >= D_CNT) begin
            rx_q <= (rx_q >> 1) | (WIDTH'(sdo) << (WIDTH - 1));
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data  = rx_q;
  assign out_match = (state == DONE) && (rx_q == tx_q);

endmodule
`default_nettype wire

// File: tb/tb_siso_loop_ctrl.sv
`default_nettype none
// ============================================================================
// tb_siso_loop_ctrl : randomized loopback bench with a word-level reference model
// Revision          : 1.0
// ============================================================================
module tb_siso_loop_ctrl;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0, in_ready, sin, sdo, out_valid, out_ready = 1'b1;
  logic         out_match, busy;
  logic [W-1:0] in_data = '0, out_data;
  logic         flip = 1'b0;

  logic         in_valid1 = 1'b0, in_ready1, sin1, out_valid1, out_match1, busy1;
  logic [0:0]   in_data1 = '0, out_data1;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // The controller's sin flop is the chain's first delay stage; D-1 more follow.
  logic [D-2:0] chain = '0;
  always @(posedge clk) chain <= {chain[D-3:0], sin};
  assign sdo = chain[D-2] ^ flip;

  siso_loop_ctrl #(.WIDTH(W), .DEPTH(D)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .sin(sin), .sdo(sdo), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_match(out_match), .busy(busy)
  );

  siso_loop_ctrl #(.WIDTH(1), .DEPTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data1), .sin(sin1), .sdo(sin1), .out_valid(out_valid1),
    .out_ready(1'b1), .out_data(out_data1), .out_match(out_match1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transfer; fbit >= 0 corrupts that bit's capture, hold = DONE backpressure cycles.
  task automatic run_xfer(input logic [W-1:0] word, input int fbit, input int hold,
                          output int acc_cycle);
    logic [W-1:0] exp_word, sin_word, held_data;
    int n, lat;
    exp_word = (fbit >= 0) ? (word ^ (W'(1) << fbit)) : word;
    out_ready = (hold == 0);
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("ready_before_accept", in_ready, 1);
    in_data  = word;
    in_valid = 1'b1;
    tick();
    acc_cycle = cyc;
    in_valid  = 1'b0;
    in_data   = W'($urandom);
    sin_word  = '0;
    lat = 0;
    while (!out_valid && lat < 60) begin
      tick();
      lat++;
      if (lat >= 1 && lat <= W) sin_word[lat-1] = sin;
      if (lat == W + 1) check("sin_idle_after_word", sin, 0);
      flip = (fbit >= 0) && (lat == D + fbit);
    end
    flip = 1'b0;
    check("latency", lat, W + D);
    check("sin_serial_word", sin_word, word);
    check("busy_in_done", busy, 1);
    check("out_data", out_data, exp_word);
    check("out_match", out_match, exp_word == word);
    held_data = out_data;
    for (int h = 0; h < hold; h++) begin
      in_valid = $urandom_range(0, 1);
      in_data  = W'($urandom);
      tick();
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, held_data);
      check("bp_match", out_match, exp_word == word);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("release_valid", out_valid, 0);
    check("release_ready", in_ready, 1);
    check("release_busy", busy, 0);
  endtask

  initial begin
    int a0, a1, lat1;
    logic [W-1:0] w;
    int fb;

    repeat (3) tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_sin", sin, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_match", out_match, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run_xfer(8'hA5, -1, 0, a0);
    run_xfer(8'h0F, 2, 0, a0);
    run_xfer(8'h5A, -1, 5, a0);

    // Abort mid-shift, then confirm nothing of the dropped word leaks out.
    in_data  = 8'hC3;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", in_ready, 1);
    check("abort_sin", sin, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_out_data", out_data, 0);
    check("abort_out_match", out_match, 0);
    check("abort_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_xfer(8'h3C, -1, 0, a0);

    run_xfer(8'hFF, -1, 0, a0);
    run_xfer(8'h00, -1, 0, a1);
    check("b2b_spacing", a1 - a0, W + D + 2);

    for (int i = 0; i < 8; i++) begin
      w  = W'($urandom);
      fb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, W - 1)) : -1;
      run_xfer(w, fb, $urandom_range(0, 3), a0);
    end

    // WIDTH=1, DEPTH=1 instance
    for (int v = 0; v < 2; v++) begin
      in_data1  = 1'(1 - v);
      in_valid1 = 1'b1;
      tick();
      in_valid1 = 1'b0;
      lat1 = 0;
      while (!out_valid1 && lat1 < 20) begin
        tick();
        lat1++;
      end
      check("w1_latency", lat1, 2);
      check("w1_out_data", out_data1, 1 - v);
      check("w1_out_match", out_match1, 1);
      tick();
      check("w1_release", in_ready1, 1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
